// File: rtl/clock_pkg.sv
// Shared time-of-day constants, FSM encoding and input normalisation helpers
// used by the setter, time keeper and display blocks.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  SEC_MAX  = 6'd59;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    // Inputs never reach twice the limit, so one conditional subtract suffices.
    function automatic logic [HOUR_W-1:0] norm_hour(input logic [HOUR_W-1:0] h);
        return (h > HOUR_MAX) ? h - (HOUR_MAX + HOUR_W'(1)) : h;
    endfunction

    function automatic logic [MIN_W-1:0] norm_min(input logic [MIN_W-1:0] m);
        return (m > MIN_MAX) ? m - (MIN_MAX + MIN_W'(1)) : m;
    endfunction

    function automatic logic [MIN_W-1:0] norm_sec(input logic [MIN_W-1:0] s);
        return (s > SEC_MAX) ? s - (SEC_MAX + MIN_W'(1)) : s;
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Setter-to-keeper inputs and keeper-to-display outputs bundled as one interface.
interface time_keeper_if;
    import clock_pkg::*;

    logic              set_mode;
    logic [HOUR_W-1:0] h_in;
    logic [MIN_W-1:0]  m_in;
    logic [MIN_W-1:0]  s_in;
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [MIN_W-1:0]  seconds;
    logic              sec_tick;
    logic              day_wrap;
    logic              running;

    modport master (
        output set_mode, h_in, m_in, s_in,
        input  hours, minutes, seconds, sec_tick, day_wrap, running
    );

    modport slave (
        input  set_mode, h_in, m_in, s_in,
        output hours, minutes, seconds, sec_tick, day_wrap, running
    );

endinterface

// File: rtl/time_keeper_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 cycle counter; wrap marks the last cycle of each second.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_at_max;

    assign w_at_max = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign wrap     = w_at_max && !clear;

    always_comb begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (clear || w_at_max) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter: follows the normalised setter values while set mode is
// active, otherwise counts seconds/minutes/hours with a 24-hour wrap.
module time_keeper
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic         clk,
    input  logic         reset,
    time_keeper_if.slave tk
);

    logic              r_sync1;
    logic              r_sync2;
    state_t            r_state;
    state_t            w_state_next;
    logic [HOUR_W-1:0] r_hours;
    logic [MIN_W-1:0]  r_minutes;
    logic [MIN_W-1:0]  r_seconds;
    logic              r_sec_tick;
    logic              r_day_wrap;
    logic [HOUR_W-1:0] w_hours_next;
    logic [MIN_W-1:0]  w_minutes_next;
    logic [MIN_W-1:0]  w_seconds_next;
    logic              w_sec_tick_next;
    logic              w_day_wrap_next;
    logic              w_set_s;
    logic              w_load;
    logic              w_wrap;

    assign w_set_s = r_sync2;
    // Loading starts as soon as set_s rises so a coincident prescaler wrap loses.
    assign w_load  = w_set_s || (r_state == SET);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= tk.set_mode;
            r_sync2 <= r_sync1;
        end
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_load),
        .wrap  (w_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_set_s)  w_state_next = SET;
            SET:     if (!w_set_s) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        w_hours_next    = r_hours;
        w_minutes_next  = r_minutes;
        w_seconds_next  = r_seconds;
        w_sec_tick_next = 1'b0;
        w_day_wrap_next = 1'b0;
        if (w_load) begin
            w_hours_next   = norm_hour(tk.h_in);
            w_minutes_next = norm_min(tk.m_in);
            w_seconds_next = norm_sec(tk.s_in);
        end else if (w_wrap) begin
            w_sec_tick_next = 1'b1;
            if (r_seconds == SEC_MAX) begin
                w_seconds_next = '0;
                if (r_minutes == MIN_MAX) begin
                    w_minutes_next = '0;
                    if (r_hours == HOUR_MAX) begin
                        w_hours_next    = '0;
                        w_day_wrap_next = 1'b1;
                    end else begin
                        w_hours_next = r_hours + HOUR_W'(1);
                    end
                end else begin
                    w_minutes_next = r_minutes + MIN_W'(1);
                end
            end else begin
                w_seconds_next = r_seconds + MIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hours    <= '0;
            r_minutes  <= '0;
            r_seconds  <= '0;
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
        end else begin
            r_hours    <= w_hours_next;
            r_minutes  <= w_minutes_next;
            r_seconds  <= w_seconds_next;
            r_sec_tick <= w_sec_tick_next;
            r_day_wrap <= w_day_wrap_next;
        end
    end

    assign tk.hours    = r_hours;
    assign tk.minutes  = r_minutes;
    assign tk.seconds  = r_seconds;
    assign tk.sec_tick = r_sec_tick;
    assign tk.day_wrap = r_day_wrap;
    assign tk.running  = (r_state == RUN);

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper with TICK_DIV=8: stimulus queues expected
// ticks (cycle, time, day_wrap); a negedge monitor checks each sec_tick.
module tb_time_keeper;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   failed;

    typedef struct {
        int          cyc;
        logic [16:0] t;
        logic        dw;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    time_keeper_if tkif ();

    time_keeper #(
        .TICK_DIV (8),
        .CNT_W    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tk    (tkif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, expv, cyc);
        end else begin
            $display("[TB] ok %s = %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check(name, {15'd0, tkif.hours, tkif.minutes, tkif.seconds},
              {15'd0, 5'(h), 6'(m), 6'(s)});
    endtask

    task automatic push_exp(input int cy, input int h, input int m, input int s, input logic dw);
        exp_t x;
        x.cyc = cy;
        x.t   = {5'(h), 6'(m), 6'(s)};
        x.dw  = dw;
        sb.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input int h, input int m, input int s);
        tkif.h_in = 5'(h);
        tkif.m_in = 6'(m);
        tkif.s_in = 6'(s);
    endtask

    // Monitor: every sec_tick must match the oldest queued expectation.
    always @(negedge clk) begin
        if (tkif.sec_tick) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_tick: got tick %0d:%0d:%0d at cycle %0d required none",
                         tkif.hours, tkif.minutes, tkif.seconds, cyc);
            end else begin
                e = sb.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_time", {15'd0, tkif.hours, tkif.minutes, tkif.seconds}, {15'd0, e.t});
                check("tick_day_wrap", {31'd0, tkif.day_wrap}, {31'd0, e.dw});
            end
        end else if (tkif.day_wrap) begin
            tests++;
            failed++;
            $display("FAIL stray_day_wrap: got day_wrap=1 without tick at cycle %0d required 0", cyc);
        end
    end

    initial begin
        int c;
        tests         = 0;
        failed        = 0;
        reset         = 1'b0;
        tkif.set_mode = 1'b0;
        drive_in(0, 0, 0);

        // Reset held for 5 cycles, then first tick 8 cycles after release.
        step(5);
        check_time("reset_time", 0, 0, 0);
        check("reset_running", {31'd0, tkif.running}, 32'd1);
        check("reset_tick", {31'd0, tkif.sec_tick}, 32'd0);
        reset = 1'b1;
        c = cyc;
        push_exp(c + 8, 0, 0, 1, 1'b0);
        step(9);

        // Set-mode latency then normalised load 31:63:60 -> 07:03:00.
        tkif.set_mode = 1'b1;
        step(2);
        check("set_latency_2", {31'd0, tkif.running}, 32'd1);
        step(1);
        check("set_latency_3", {31'd0, tkif.running}, 32'd0);
        drive_in(31, 63, 60);
        step(1);
        check_time("norm_load", 7, 3, 0);

        // Full day wrap from 23:59:58.
        drive_in(23, 59, 58);
        step(1);
        check_time("load_235958", 23, 59, 58);
        tkif.set_mode = 1'b0;
        c = cyc;
        push_exp(c + 11, 23, 59, 59, 1'b0);
        push_exp(c + 19, 0, 0, 0, 1'b1);
        step(20);
        check("day_wrap_width", {31'd0, tkif.day_wrap}, 32'd0);
        check_time("post_wrap_time", 0, 0, 0);
        tkif.set_mode = 1'b1;
        step(4);

        // Carry 10:59:59 -> 11:00:00, then set_s rises in the next wrap cycle.
        drive_in(10, 59, 59);
        step(1);
        check_time("load_105959", 10, 59, 59);
        tkif.set_mode = 1'b0;
        c = cyc;
        push_exp(c + 11, 11, 0, 0, 1'b0);
        step(16);
        tkif.set_mode = 1'b1;
        drive_in(29, 45, 62);
        step(3);
        check_time("set_wins_time", 5, 45, 2);
        check("set_wins_tick", {31'd0, tkif.sec_tick}, 32'd0);
        check("set_wins_running", {31'd0, tkif.running}, 32'd0);

        // Asynchronous reset at prescaler count 5 while showing 12:34:56.
        drive_in(12, 34, 56);
        step(1);
        check_time("load_123456", 12, 34, 56);
        tkif.set_mode = 1'b0;
        step(8);
        check_time("pre_reset_time", 12, 34, 56);
        reset = 1'b0;
        #1;
        check_time("async_reset_time", 0, 0, 0);
        check("async_reset_running", {31'd0, tkif.running}, 32'd1);
        step(1);
        reset = 1'b1;
        c = cyc;
        push_exp(c + 8, 0, 0, 1, 1'b0);
        step(10);

        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drained: got %0d pending ticks required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
# time_keeper

Run-time counting stage fed directly by the time-setting block. While set mode is active it tracks the hour/minute/second values produced by the setter, normalising out-of-range values into legal time. When set mode is released it counts real time from that value: 1 Hz seconds, minutes and hours on a 24-hour wrap. Its outputs drive the display path.

## Interface
Parameters:
- `TICK_DIV`, 100_000_000: clock cycles per second. Must be ≥ 2; benches use 8.
- `CNT_W`, 27: prescaler width. Must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-low reset. Asserted when 0.
- `set_mode`  in  1  raw slide switch. 1 = set, 0 = run. Asynchronous to `clk`.
- `h_in`  in  5  hour value from the setter, 0..31.
- `m_in`  in  6  minute value from the setter, 0..63.
- `s_in`  in  6  second value from the setter, 0..63.
- `hours`  out  5  current hour, 0..23.
- `minutes`  out  6  current minute, 0..59.
- `seconds`  out  6  current second, 0..59.
- `sec_tick`  out  1  one-cycle pulse on every seconds advance in run.
- `day_wrap`  out  1  one-cycle pulse on the 23:59:59→00:00:00 advance.
- `running`  out  1  1 while in state RUN.

## Operation
- **Synchroniser.** `set_mode` passes through a 2-flop synchroniser, giving `set_s`. The FSM uses `set_s` only.
- **FSM state RUN** (reset state):
  - The prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - On the wrap cycle, seconds increments.
- **Seconds, minutes and hours carry:**
  - seconds 59→0 carries into minutes.
  - minutes 59→0 carries into hours.
  - hours 23→0 asserts `day_wrap`.
- **RUN → SET** when `set_s`=1.
- **FSM state SET:**
  - Prescaler is held at 0. `sec_tick` and `day_wrap` are 0.
  - Every cycle, the time registers load the normalised inputs.
- **SET → RUN** when `set_s`=0. The prescaler restarts from 0.
- **Normalisation** is a single conditional subtract, valid because every input is below twice its limit:
  - hour = h_in ≥ 24 ? h_in−24 : h_in
  - minute = m_in ≥ 60 ? m_in−60 : m_in
  - second = s_in ≥ 60 ? s_in−60 : s_in
- **Arithmetic width.** All arithmetic is unsigned at port width. No intermediate result exceeds the port width.
- **Reset.** Assertion at any time, including mid-carry, takes effect immediately:
  - state RUN
  - prescaler 0
  - hours, minutes, seconds = 0
  - `sec_tick`, `day_wrap` = 0
  - `running` = 1
  - synchroniser flops = 0

## Timing
- **Set-mode latency.** A change on `set_mode` reaches the state register after 3 `clk` edges: 2 synchroniser edges plus 1 FSM edge.
- **Input-to-output latency in SET.** An input change appears on `hours`/`minutes`/`seconds` 1 cycle later.
- **Tick timing.** `sec_tick` is registered. It is high in the same cycle the new `seconds` value is visible.
- **First tick after SET→RUN.** The first `sec_tick` comes exactly TICK_DIV cycles after the first RUN cycle. Subsequent ticks are TICK_DIV cycles apart.
- **Day wrap.** `day_wrap` coincides with the `sec_tick` that produces 00:00:00.
- **Tick coinciding with set.** If the prescaler wrap and `set_s`=1 occur in the same cycle, SET wins. No increment and no tick occur; inputs load.
- **Reset release.** The first tick comes TICK_DIV cycles after the first clock edge with `reset`=1.

## Structure
- **Shared package `clock_pkg`.** Holds:
  - `HOUR_W`=5, `MIN_W`=6
  - `HOUR_MAX`=23, `MIN_MAX`=59, `SEC_MAX`=59
  - FSM state encoding: RUN=1'b0, SET=1'b1

  The setter and display blocks use the same constants.
- **Sub-module `tick_prescaler`.**
  - Parameterised by `TICK_DIV` and `CNT_W`.
  - Input `clear`, output `wrap`.
  - Instantiated once.
  - The carry chain and FSM stay in `time_keeper`.

## Test plan
- **Reset value.** Hold `reset`=0 for 5 cycles, then release with TICK_DIV=8. Expect:
  - 00:00:00 and `running`=1 while reset is held.
  - First `sec_tick` and seconds=1 exactly 8 cycles after release.
- **Normalised load.** Set `set_mode`=1 and drive h_in=31, m_in=63, s_in=60. Expect:
  - `running`=0 three cycles later.
  - Outputs 07:03:00 one cycle after the inputs are stable.
- **Full wrap.** Load 23:59:58, then set `set_mode`=0. Expect:
  - Two ticks 8 cycles apart.
  - Second tick gives 00:00:00 with `day_wrap`=1 for exactly one cycle.
- **Carry.** Load 10:59:59, then run. One tick gives 11:00:00 with `day_wrap`=0.
- **Set wins.** Assert `set_mode` so that `set_s` rises in the prescaler wrap cycle. Expect no `sec_tick` and time equal to the normalised inputs.
- **Mid-run reset.** Pulse `reset`=0 for 1 cycle at prescaler count 5, time 12:34:56. Expect:
  - Immediate 00:00:00.
  - Next tick 8 cycles after release.
